// File: rtl/node_unloader_pkg.sv
// Shared definitions for the node unloader: FSM state encoding, write-enable pattern
// and counter sizing helper.
package node_unloader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WE_ALL = 8'hFF;

  // Word counter width; a single-word unload still needs a 1-bit counter.
  function automatic int cnt_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

endpackage

// File: rtl/node_unloader_shift_out.sv
// Parallel-load, serial-out word shifter feeding the unloader bus.
// UNLOAD_REVERSE_EN: shift toward the MSBs and present the top word (highest index first).
module node_unloader_shift_out #(
  parameter int N   = 16,
  parameter int CNT = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [N*CNT-1:0]   i_data,
  input  logic               i_shift,
  output logic [N-1:0]       o_word
);

  logic [N*CNT-1:0] r_buf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_data;
    end else if (i_shift) begin
`ifdef UNLOAD_REVERSE_EN
      r_buf <= r_buf << N;
`else
      r_buf <= r_buf >> N;
`endif
    end
  end

`ifdef UNLOAD_REVERSE_EN
  assign o_word = r_buf[N*CNT-1 -: N];
`else
  assign o_word = r_buf[N-1:0];
`endif

endmodule

// File: rtl/node_unloader.sv
// Serialises a CNT-word snapshot onto the shared bus, one word per granted cycle,
// with matching RAM address/write-enable. Word order selectable via UNLOAD_REVERSE_EN.
module node_unloader
  import node_unloader_pkg::*;
#(
  parameter int N      = 16,
  parameter int CNT    = 7,
  parameter int A      = 32,
  parameter int STRIDE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N*CNT-1:0]   i_data_in,
  input  logic [A-1:0]       i_base_addr,
  input  logic               i_bus_gnt,
  output logic [N-1:0]       o_bus_out,
  output logic               o_bus_oe,
  output logic [A-1:0]       o_mem_addr,
  output logic [7:0]         o_mem_we,
  output logic               o_busy,
  output logic               o_done
);

  localparam int KW = cnt_width(CNT);

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [A-1:0]    r_addr;
  logic            r_busy;
  logic            r_done;

  logic            w_load;
  logic            w_beat;
  logic            w_last;

  assign w_load = (r_state == IDLE) && i_start;
  assign w_beat = (r_state == XFER) && i_bus_gnt;
  assign w_last = (r_k == KW'(CNT - 1));

  node_unloader_shift_out #(
    .N   (N),
    .CNT (CNT)
  ) u_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (i_data_in),
    .i_shift (w_beat),
    .o_word  (o_bus_out)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (i_bus_gnt) begin
            // Address wraps modulo 2^A by plain truncation.
            r_addr <= r_addr + A'(STRIDE);
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Drive enable follows the grant within the beat so a stalled cycle never writes.
  assign o_bus_oe   = w_beat;
  assign o_mem_we   = w_beat ? WE_ALL : 8'h00;
  assign o_mem_addr = r_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
